ct_spsram_param_init: RTL and testbench

CT_SPSRAM_PARAM_INIT -- requirements
Module: ct_spsram_param_init

---
 rtl/ct_spsram_param_init.sv | 167 ++++++++++++++++
 tb/tb_ct_spsram_param_init.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ct_spsram_param_init.sv
// Single-port SRAM with per-lane write enables and a power-up sweep.
// Accesses are ignored until every word has been written with INIT_VALUE.
module ct_spsram_param_init #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 7,
  parameter int                    WE_WIDTH   = 7,
  parameter int                    OUT_REG    = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [WE_WIDTH-1:0]   WEN,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  QVLD,
  output logic                  INIT_BUSY
);

  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int LANE_W = DATA_WIDTH / WE_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST =
    (ADDR_WIDTH+1)'(DEPTH - 1);

  typedef enum logic {
    S_INIT,
    S_READY
  } state_e;

  state_e                state_q;
  state_e                state_d;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic [ADDR_WIDTH:0]   cnt_d;

  logic                  mem_we;
  logic [WE_WIDTH-1:0]   mem_lane_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  rd_req;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] rd_data_d;
  logic                  rd_vld_q;
  logic                  rd_vld_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_READY;
        end
      end
      S_READY: begin
        cnt_d = '0;
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    INIT_BUSY   = 1'b0;
    mem_we      = 1'b0;
    mem_lane_we = '0;
    mem_addr    = A;
    mem_wdata   = D;
    rd_req      = 1'b0;
    unique case (state_q)
      S_INIT: begin
        INIT_BUSY   = 1'b1;
        mem_we      = 1'b1;
        mem_lane_we = '1;
        mem_addr    = cnt_q[ADDR_WIDTH-1:0];
        mem_wdata   = INIT_VALUE;
      end
      S_READY: begin
        mem_we      = !CEN && !GWEN;
        mem_lane_we = ~WEN;
        rd_req      = !CEN && GWEN;
      end
      default: begin
        INIT_BUSY = 1'b1;
      end
    endcase
  end

  // array has no reset; only the sweep defines its contents
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int k = 0; k < WE_WIDTH; k++) begin
        if (mem_lane_we[k]) begin
          mem_q[mem_addr][k*LANE_W +: LANE_W] <=
            mem_wdata[k*LANE_W +: LANE_W];
        end
      end
    end
  end

  always_comb begin
    rd_vld_d  = rd_req;
    rd_data_d = rd_data_q;
    if (rd_req) begin
      rd_data_d = mem_q[A];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_vld_q  <= rd_vld_d;
      rd_data_q <= rd_data_d;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_WIDTH-1:0] q_q;
    logic [DATA_WIDTH-1:0] q_d;
    logic                  qvld_q;
    logic                  qvld_d;

    always_comb begin
      qvld_d = rd_vld_q;
      q_d    = q_q;
      if (rd_vld_q) begin
        q_d = rd_data_q;
      end
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        qvld_q <= 1'b0;
        q_q    <= '0;
      end else begin
        qvld_q <= qvld_d;
        q_q    <= q_d;
      end
    end

    assign Q    = q_q;
    assign QVLD = qvld_q;
  end else begin : g_noreg
    assign Q    = rd_data_q;
    assign QVLD = rd_vld_q;
  end

endmodule

// File: tb/tb_ct_spsram_param_init.sv
// Bench for ct_spsram_param_init: two instances (OUT_REG 0 and 1) share
// stimulus; a memory model feeds a read scoreboard drained by a monitor.
module tb_ct_spsram_param_init;

  localparam int AW    = 8;
  localparam int DW    = 7;
  localparam int WW    = 7;
  localparam int DEPTH = 256;
  localparam int LW    = DW / WW;
  localparam logic [DW-1:0] INIT0 = '0;
  localparam logic [DW-1:0] INIT1 = 7'h2A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          cen;
  logic          gwen;
  logic [WW-1:0] wen;
  logic [AW-1:0] a;
  logic [DW-1:0] d;
  logic [DW-1:0] q0, q1;
  logic          qv0, qv1;
  logic          busy0, busy1;

  ct_spsram_param_init #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW),
    .OUT_REG(0), .INIT_VALUE(INIT0)
  ) u_dut0 (
    .CLK(clk), .RST(rst), .A(a), .CEN(cen), .GWEN(gwen),
    .WEN(wen), .D(d), .Q(q0), .QVLD(qv0), .INIT_BUSY(busy0)
  );

  ct_spsram_param_init #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW),
    .OUT_REG(1), .INIT_VALUE(INIT1)
  ) u_dut1 (
    .CLK(clk), .RST(rst), .A(a), .CEN(cen), .GWEN(gwen),
    .WEN(wen), .D(d), .Q(q1), .QVLD(qv1), .INIT_BUSY(busy1)
  );

  typedef struct {
    int          port;
    int          due;
    logic [DW-1:0] data;
  } rd_t;

  rd_t           sb[$];
  logic [DW-1:0] mem [2][DEPTH];
  logic [DW-1:0] mq [2];
  int            left = 0;
  bit            busy_nx = 1'b1;
  bit            busy_now = 1'b1;
  bit            rst_nx = 1'b0;
  bit            rst_now = 1'b0;
  bit            done = 1'b0;
  int            edges = 0;
  int            nvec = 0;
  int            nerr = 0;

  always @(posedge clk) edges <= edges + 1;

  // model state after the coming edge; *_now is the state after the last
  task automatic drive(input logic r, input logic c, input logic g,
                       input logic [WW-1:0] w, input logic [AW-1:0] ad,
                       input logic [DW-1:0] dd);
    int ne;
    rst = r; cen = c; gwen = g; wen = w; a = ad; d = dd;
    busy_now = busy_nx;
    rst_now  = rst_nx;
    ne       = edges + 1;
    rst_nx   = r;
    if (r) begin
      left    = DEPTH;
      busy_nx = 1'b1;
      for (int i = sb.size() - 1; i >= 0; i--)
        if (sb[i].due >= ne) sb.delete(i);
    end else if (left > 0) begin
      left--;
      busy_nx = (left > 0);
      if (left == 0)
        for (int i = 0; i < DEPTH; i++) begin
          mem[0][i] = INIT0;
          mem[1][i] = INIT1;
        end
    end else if (!c) begin
      if (!g) begin
        for (int p = 0; p < 2; p++)
          for (int b = 0; b < DW; b++)
            if (!w[b/LW]) mem[p][ad][b] = dd[b];
      end else begin
        sb.push_back('{0, ne, mem[0][ad]});
        sb.push_back('{1, ne + 1, mem[1][ad]});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b1, 1'b1, '1, '0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] ad);
    drive(1'b0, 1'b0, 1'b1, '1, ad, '0);
  endtask

  task automatic wr(input logic [AW-1:0] ad, input logic [DW-1:0] dd,
                    input logic [WW-1:0] w);
    drive(1'b0, 1'b0, 1'b0, w, ad, dd);
  endtask

  task automatic do_rst();
    drive(1'b1, 1'b1, 1'b1, '1, '0, '0);
  endtask

  function automatic int find(input int p);
    for (int i = 0; i < sb.size(); i++)
      if (sb[i].port == p) return i;
    return -1;
  endfunction

  task automatic chk(input int p, input logic [DW-1:0] q,
                     input logic qv, input logic bz);
    int i;
    nvec++;
    if (bz !== busy_now) begin
      nerr++;
      $display("FAIL init_busy port%0d edge %0d: got %b want %b",
               p, edges, bz, busy_now);
    end
    if (rst_now) mq[p] = '0;
    i = find(p);
    while (i >= 0 && sb[i].due < edges) begin
      nerr++;
      $display("FAIL missing_qvld port%0d edge %0d: want data %h due %0d",
               p, edges, sb[i].data, sb[i].due);
      sb.delete(i);
      i = find(p);
    end
    nvec++;
    if (qv) begin
      if (i < 0 || sb[i].due != edges) begin
        nerr++;
        $display("FAIL spurious_qvld port%0d edge %0d: got qvld 1 want 0",
                 p, edges);
      end else begin
        if (q !== sb[i].data) begin
          nerr++;
          $display("FAIL read_data port%0d edge %0d: got %h want %h",
                   p, edges, q, sb[i].data);
        end
        mq[p] = sb[i].data;
        sb.delete(i);
      end
    end else if (q !== mq[p]) begin
      nerr++;
      $display("FAIL q_hold port%0d edge %0d: got %h want %h",
               p, edges, q, mq[p]);
    end
  endtask

  always @(negedge clk) begin
    if (edges > 0 && !done) begin
      chk(0, q0, qv0, busy0);
      chk(1, q1, qv1, busy1);
    end
  end

  initial begin
    mq[0] = '0;
    mq[1] = '0;
    do_rst();
    do_rst();
    // junk accesses during the sweep must be ignored
    for (int i = 0; i < DEPTH; i++)
      drive(1'b0, 1'($urandom), 1'($urandom), WW'($urandom),
            AW'($urandom), DW'($urandom));
    idle();
    rd(8'h00);
    rd(8'hFF);
    idle();
    wr(8'h12, 7'h55, 7'h00);
    rd(8'h12);
    wr(8'h13, 7'h33, 7'h00);
    idle();
    idle();
    wr(8'h12, 7'h00, 7'b1111110);
    rd(8'h12);
    wr(8'h12, 7'h00, 7'h7F);
    rd(8'h12);
    idle();
    idle();
    // reset in READY, then again mid-sweep
    do_rst();
    for (int i = 0; i < 100; i++) idle();
    do_rst();
    for (int i = 0; i < DEPTH; i++) wr(8'h05, 7'h7F, 7'h00);
    idle();
    rd(8'h05);
    rd(8'h12);
    idle();
    wr(8'h01, 7'h11, 7'h00);
    wr(8'h02, 7'h22, 7'h00);
    wr(8'h03, 7'h33, 7'h00);
    rd(8'h01);
    rd(8'h02);
    rd(8'h03);
    idle();
    idle();
    idle();
    for (int i = 0; i < 400; i++)
      drive(1'b0, 1'($urandom_range(0, 3) == 0), 1'($urandom),
            ($urandom_range(0, 2) == 0) ? '1 : WW'($urandom),
            AW'($urandom_range(0, 15)), DW'($urandom));
    idle();
    idle();
    // read in flight when reset hits
    rd(8'h03);
    do_rst();
    for (int i = 0; i < DEPTH + 2; i++) idle();
    rd(8'h03);
    rd(8'h12);
    for (int i = 0; i < 4; i++) idle();
    done = 1'b1;
    nvec++;
    if (sb.size() != 0) begin
      nerr++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
